// File: rtl/dv_stim_player.sv
// Timed-packet replay source: preloaded buffer played onto an access/packet/wait link.
// Optional accepted-packet counter output stim_sent under `define DV_STIM_COUNT_EN.
module dv_stim_player #(
  parameter int PW   = 104,
  parameter int AW   = 10,
  parameter int DLYW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 load_en,
  input  logic [AW-1:0]        load_addr,
  input  logic [DLYW+PW-1:0]   load_data,
  input  logic [AW:0]          stim_count,
  input  logic                 wait_in,
  output logic                 access_out,
  output logic [PW-1:0]        packet_out,
  output logic                 stim_busy,
  output logic                 stim_done
`ifdef DV_STIM_COUNT_EN
  ,
  output logic [AW:0]          stim_sent
`endif
);

  localparam int EW = DLYW + PW;
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DELAY,
    S_SEND,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic            start_q;
  logic [AW:0]     ptr, ptr_nx;
  logic [AW:0]     cnt_q, cnt_nx;
  logic [DLYW-1:0] dly_q, dly_nx;
  logic [PW-1:0]   pkt_q, pkt_nx;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [EW-1:0]   rd_data;
  logic            accept;
  logic            last;

  logic [EW-1:0]   mem [2**AW];

  // Buffer has no reset: contents survive a bench reset
  always_ff @(posedge clk) begin
    if (load_en && state == S_IDLE)
      mem[load_addr] <= load_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

  assign accept = (state == S_SEND) && !wait_in;
  assign last   = (ptr == cnt_q - ONE);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt_q;
    dly_nx   = dly_q;
    pkt_nx   = pkt_q;
    rd_en    = 1'b0;
    rd_addr  = ptr[AW-1:0];
    unique case (state)
      S_IDLE: begin
        if (start_q) begin
          if (stim_count == '0) begin
            state_nx = S_DONE;
          end else begin
            cnt_nx   = stim_count;
            ptr_nx   = '0;
            rd_en    = 1'b1;
            rd_addr  = '0;
            state_nx = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        pkt_nx   = rd_data[PW-1:0];
        dly_nx   = rd_data[EW-1:PW];
        state_nx = (dly_nx == '0) ? S_SEND : S_DELAY;
      end
      S_DELAY: begin
        if (dly_q <= DLYW'(1))
          state_nx = S_SEND;
        else
          dly_nx = dly_q - DLYW'(1);
      end
      S_SEND: begin
        if (accept) begin
          if (last) begin
            state_nx = S_DONE;
          end else begin
            ptr_nx   = ptr + ONE;
            rd_en    = 1'b1;
            rd_addr  = ptr_nx[AW-1:0];
            state_nx = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_nx = S_DONE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      ptr     <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
      pkt_q   <= '0;
    end else begin
      state   <= state_nx;
      start_q <= start;
      ptr     <= ptr_nx;
      cnt_q   <= cnt_nx;
      dly_q   <= dly_nx;
      pkt_q   <= pkt_nx;
    end
  end

  assign access_out = (state == S_SEND);
  assign packet_out = pkt_q;
  assign stim_busy  = (state == S_FETCH) || (state == S_DELAY) ||
                      (state == S_SEND);
  assign stim_done  = (state == S_DONE);

`ifdef DV_STIM_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stim_sent <= '0;
    else if (accept)
      stim_sent <= stim_sent + ONE;
  end
`endif

endmodule

// File: tb/tb_dv_stim_player.sv
// Scoreboard bench for dv_stim_player: random and directed replay runs
// checked against a packet/delay model of the buffer.
module tb_dv_stim_player;

  localparam int PW   = 104;
  localparam int AW   = 2;
  localparam int DLYW = 16;
  localparam int EW   = DLYW + PW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            load_en = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [EW-1:0]   load_data = '0;
  logic [AW:0]     stim_count = '0;
  logic            wait_in = 1'b0;
  logic            access_out;
  logic [PW-1:0]   packet_out;
  logic            stim_busy;
  logic            stim_done;
`ifdef DV_STIM_COUNT_EN
  logic [AW:0]     stim_sent;
`endif

  dv_stim_player #(.PW(PW), .AW(AW), .DLYW(DLYW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .stim_count (stim_count),
    .wait_in    (wait_in),
    .access_out (access_out),
    .packet_out (packet_out),
    .stim_busy  (stim_busy),
    .stim_done  (stim_done)
`ifdef DV_STIM_COUNT_EN
    ,
    .stim_sent  (stim_sent)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DLYW-1:0] m_dly [4];
  logic [PW-1:0]   m_pkt [4];
  logic [PW-1:0]   exp_q [$];
  int              acc_k [$];

  bit wait_hold = 1'b0;
  bit rand_wait = 1'b0;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Backpressure driver
  always @(posedge clk) begin
    #1;
    if (wait_hold)
      wait_in = 1'b1;
    else if (rand_wait)
      wait_in = ($urandom_range(0, 2) == 0);
    else
      wait_in = 1'b0;
  end

  // Monitor: pops expected packet on every acceptance
  logic          prev_hold = 1'b0;
  logic [PW-1:0] prev_pkt = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && access_out)
        chk("pkt_stable", 128'(packet_out), 128'(prev_pkt));
      if (access_out && !wait_in) begin
        if (exp_q.size() == 0)
          chk("unexpected_pkt", 128'(packet_out), 128'(1'bx));
        else
          chk("packet", 128'(packet_out), 128'(exp_q.pop_front()));
      end
      prev_hold = access_out && wait_in;
      prev_pkt  = packet_out;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic load(input int a, input logic [DLYW-1:0] d,
                      input logic [PW-1:0] p);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = {d, p};
    m_dly[a]  = d;
    m_pkt[a]  = p;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic run(input int cnt, input int hold,
                     output int lat, output int n_high, output int done_k);
    logic [127:0] junk;
    lat = -1;
    n_high = 0;
    done_k = -1;
    acc_k.delete();
    for (int i = 0; i < cnt; i++)
      exp_q.push_back(m_pkt[i % 4]);
    wait_hold = (hold > 0);
    @(negedge clk);
    stim_count = (AW+1)'(cnt);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #2;
      if (k == 3) begin
        junk = {$urandom, $urandom, $urandom, $urandom};
        stim_count = (AW+1)'($urandom);
        load_en   = 1'b1;
        load_addr = AW'($urandom);
        load_data = junk[EW-1:0];
      end
      if (k == 4)
        load_en = 1'b0;
      if (access_out) begin
        if (lat < 0)
          lat = k;
        n_high++;
        if (!wait_in)
          acc_k.push_back(k);
      end
      if (hold > 0 && n_high == hold)
        wait_hold = 1'b0;
      if (stim_done) begin
        done_k = k;
        break;
      end
    end
    load_en = 1'b0;
    wait_hold = 1'b0;
    chk("stim_done", 128'(stim_done), 128'(1));
    chk("busy_done", 128'(stim_busy), 128'(0));
    chk("access_done", 128'(access_out), 128'(0));
    chk("accept_cnt", 128'(acc_k.size()), 128'(cnt));
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
`ifdef DV_STIM_COUNT_EN
    chk("stim_sent", 128'(stim_sent), 128'(cnt));
`endif
    if (cnt > 0 && acc_k.size() > 0) begin
      chk("first_lat", 128'(lat), 128'(2 + int'(m_dly[0])));
      chk("done_lat", 128'(done_k), 128'(acc_k[acc_k.size()-1] + 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nh, dk;
    logic [127:0] r;

    do_reset();
    chk("rst_access", 128'(access_out), 128'(0));
    chk("rst_packet", 128'(packet_out), 128'(0));
    chk("rst_busy", 128'(stim_busy), 128'(0));
    chk("rst_done", 128'(stim_done), 128'(0));
`ifdef DV_STIM_COUNT_EN
    chk("rst_sent", 128'(stim_sent), 128'(0));
`endif

    // Back-to-back replay, zero delay
    load(0, 0, 104'h11);
    load(1, 0, 104'h22);
    load(2, 0, 104'h33);
    load(3, 0, 104'h44);
    run(4, 0, lat, nh, dk);
    chk("acc_cyc0", 128'(acc_k[0]), 128'(2));
    chk("acc_cyc1", 128'(acc_k[1]), 128'(4));
    chk("acc_cyc2", 128'(acc_k[2]), 128'(6));
    chk("acc_cyc3", 128'(acc_k[3]), 128'(8));
    chk("done_cyc", 128'(dk), 128'(9));

    // First entry delayed
    do_reset();
    load(0, 5, 104'hAB);
    run(1, 0, lat, nh, dk);
    chk("delay5_lat", 128'(lat), 128'(7));

    // Long backpressure on the first send
    do_reset();
    load(0, 0, 104'h11);
    run(1, 10, lat, nh, dk);
    chk("hold_high", 128'(nh), 128'(11));

    // Zero count
    do_reset();
    run(0, 0, lat, nh, dk);
    chk("zero_done_cyc", 128'(dk), 128'(1));
    chk("zero_no_access", 128'(nh), 128'(0));

    // Reset during the 2nd packet's delay, then replay without reload
    do_reset();
    load(0, 0, 104'h11);
    load(1, 6, 104'h22);
    load(2, 0, 104'h33);
    load(3, 0, 104'h44);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(m_pkt[i]);
    @(negedge clk);
    stim_count = 3'd4;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #2;
      if (access_out && !wait_in)
        break;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", 128'(stim_busy), 128'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_access", 128'(access_out), 128'(0));
    chk("mid_rst_packet", 128'(packet_out), 128'(0));
    chk("mid_rst_busy", 128'(stim_busy), 128'(0));
    chk("mid_rst_done", 128'(stim_done), 128'(0));
    do_reset();
    run(4, 0, lat, nh, dk);

    // Address wrap beyond buffer depth
    do_reset();
    load(1, 0, 104'h22);
    run(6, 0, lat, nh, dk);

    // Random entries, counts and backpressure
    rand_wait = 1'b1;
    for (int t = 0; t < 10; t++) begin
      do_reset();
      for (int a = 0; a < 4; a++) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        load(a, DLYW'($urandom_range(0, 3)), r[PW-1:0]);
      end
      run($urandom_range(0, 7), 0, lat, nh, dk);
    end
    rand_wait = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dv_stim_player.md
Name: dv_stim_player

Overview:
- Stimulus source for directed DV benches. Sits between the bench clock/reset/start controller and the DUT input port.
- An internal buffer is preloaded with timed packets through a load port. After `start` is seen, the entries are replayed onto an access/packet/wait link.
- Drives `stim_done` back to the controller once the last entry has been accepted.

Parameters:
- PW, 104, packet width in bits.
- AW, 10, buffer address width; depth is 2^AW entries.
- DLYW, 16, width of the per-entry delay field; entry width = DLYW+PW.

Ports:
- clk  input  1  main clock
- reset  input  1  asynchronous active-high reset
- start  input  1  level; begin playback when high in IDLE
- load_en  input  1  buffer write strobe
- load_addr  input  AW  buffer write address
- load_data  input  DLYW+PW  entry: [DLYW+PW-1:PW]=delay, [PW-1:0]=packet
- stim_count  input  AW+1  number of entries to play; sampled when leaving IDLE
- wait_in  input  1  DUT backpressure; packet accepted on a cycle with access_out=1 and wait_in=0
- access_out  output  1  packet valid
- packet_out  output  PW  packet data
- stim_busy  output  1  high in any state other than IDLE/DONE
- stim_done  output  1  sticky high once all entries have been accepted

Behaviour:
- Reset (async, active-high) clears state, pointer, counters and outputs:
  - access_out=0, packet_out=0, stim_busy=0, stim_done=0, state=IDLE.
  - Buffer contents are not reset and are retained across reset.
- Buffer: synchronous write when load_en=1, honoured only in IDLE (ignored otherwise). Synchronous read with 1-cycle latency.
- Internal pointer ptr is AW+1 bits. Read address = ptr[AW-1:0], so stim_count > 2^AW wraps and replays from entry 0.
- IDLE:
  - start=1 with stim_count=0: go to DONE.
  - start=1 with stim_count>0: latch count, ptr=0, issue read of entry 0, go to FETCH.
- FETCH:
  - Capture entry: packet register = packet field; delay counter = delay field.
  - Delay=0: go to SEND. Otherwise go to DELAY.
- DELAY: decrement the counter each cycle. When the counter reaches 1, go to SEND. The total gap is exactly `delay` cycles between FETCH and SEND.
- SEND:
  - access_out=1; packet_out holds the captured packet, stable while wait_in=1.
  - On acceptance (wait_in=0) with ptr==count-1: go to DONE.
  - On acceptance otherwise: ptr++, issue the next read, go to FETCH.
  - access_out deasserts on the cycle after acceptance.
- DONE: stim_done=1, access_out=0. Held until reset; start is ignored.
- Latency and throughput:
  - start sampled at edge N: first access_out high after edge N+2 when delay=0.
  - Peak throughput is 1 packet per 2 cycles.
- Boundary conditions:
  - start deasserting after leaving IDLE has no effect; the run completes.
  - wait_in held high indefinitely: SEND is held, no timeout (the controller owns the timeout).
  - wait_in toggling during DELAY/FETCH is ignored.
  - stim_count changing mid-run is ignored, because the value is latched.
  - Reset asserted mid-packet drops access_out immediately.

Optional Feature:
- Macro DV_STIM_COUNT_EN.
- Defined: adds output port stim_sent [AW:0], the count of accepted packets.
  - Reset 0; increments on each acceptance.
  - Equals stim_count when stim_done rises.
  - Holds its value in DONE.
- Undefined: port and counter absent; no other behavioural difference.

Test Plan:
- Load 4 entries (delay 0, packets 0x11,0x22,0x33,0x44), stim_count=4, wait_in=0, start=1 → access_out pulses on cycles 2,4,6,8 after start with packets in order. stim_done rises on the cycle after the 4th acceptance; stim_sent=4 (DV_STIM_COUNT_EN defined).
- Entry 0 delay=5, packet 0xAB → access_out first high 7 cycles after start (2 + 5).
- wait_in=1 for 10 cycles during the first SEND → access_out stays high and packet_out stays 0x11 for 11 cycles; exactly one acceptance; stim_sent=1.
- stim_count=0, start=1 → DONE next cycle; stim_done=1; access_out never asserts.
- Reset pulsed during the 2nd packet's DELAY → all outputs 0 immediately. Re-start without reloading → the same 4 packets replay correctly (buffer retained).
- AW=2, stim_count=6 → packets 0x11,0x22,0x33,0x44,0x11,0x22 (address wrap); load_en pulses during the run do not alter the replay.
